// File: rtl/cpu_run_controller.sv
// Run sequencer for the single-cycle CPU: holds it in reset, releases it on start,
// counts executed cycles and stops it on halt, PC freeze or cycle budget.
module cpu_run_controller #(
  parameter int unsigned RESET_CYCLES = 2,
  parameter int unsigned MAX_CYCLES   = 100000000,
  parameter int unsigned STALL_WINDOW = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        halt_in,
  input  logic [31:0] pc,
  output logic        cpu_rst,
  output logic        cpu_en,
  output logic [31:0] cycles_consumed,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic        stalled
);

  localparam int unsigned HOLD_W  = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int unsigned STALL_W = (STALL_WINDOW > 1) ? $clog2(STALL_WINDOW) : 1;
  localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_WINDOW - 1);
  localparam logic [31:0]        CYC_LAST   = 32'(MAX_CYCLES - 1);
  localparam logic [31:0]        CYC_SAT    = 32'hFFFF_FFFF;
  localparam logic               STALL_EN   = (STALL_WINDOW != 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t               state, state_d;
  logic [HOLD_W-1:0]    hold_cnt, hold_cnt_d;
  logic [STALL_W-1:0]   stall_cnt, stall_cnt_d;
  logic [31:0]          pc_prev, pc_prev_d;
  logic                 pc_valid, pc_valid_d;
  logic [31:0]          cycles_d;
  logic                 timeout_d, stalled_d;
  logic                 cpu_rst_d, cpu_en_d, busy_d, done_d;
  logic                 pc_match;

  assign pc_match = pc_valid && (pc == pc_prev);

  // State and all output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= IDLE;
      hold_cnt        <= '0;
      stall_cnt       <= '0;
      pc_prev         <= '0;
      pc_valid        <= 1'b0;
      cycles_consumed <= '0;
      timeout         <= 1'b0;
      stalled         <= 1'b0;
      cpu_rst         <= 1'b0;
      cpu_en          <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      state           <= state_d;
      hold_cnt        <= hold_cnt_d;
      stall_cnt       <= stall_cnt_d;
      pc_prev         <= pc_prev_d;
      pc_valid        <= pc_valid_d;
      cycles_consumed <= cycles_d;
      timeout         <= timeout_d;
      stalled         <= stalled_d;
      cpu_rst         <= cpu_rst_d;
      cpu_en          <= cpu_en_d;
      busy            <= busy_d;
      done            <= done_d;
    end
  end

  // Next state plus run bookkeeping; exit checks use pre-increment values
  always_comb begin
    state_d     = state;
    hold_cnt_d  = hold_cnt;
    stall_cnt_d = stall_cnt;
    pc_prev_d   = pc_prev;
    pc_valid_d  = pc_valid;
    cycles_d    = cycles_consumed;
    timeout_d   = timeout;
    stalled_d   = stalled;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_d     = HOLD;
          hold_cnt_d  = HOLD_LOAD;
          stall_cnt_d = '0;
          pc_valid_d  = 1'b0;
          cycles_d    = '0;
          timeout_d   = 1'b0;
          stalled_d   = 1'b0;
        end
      end
      HOLD: begin
        if (abort) begin
          state_d = IDLE;
        end else if (hold_cnt == '0) begin
          state_d = RUN;
        end else begin
          hold_cnt_d = hold_cnt - HOLD_W'(1);
        end
      end
      RUN: begin
        cycles_d    = (cycles_consumed == CYC_SAT) ? cycles_consumed
                                                   : cycles_consumed + 32'd1;
        pc_prev_d   = pc;
        pc_valid_d  = 1'b1;
        stall_cnt_d = pc_match ? stall_cnt + STALL_W'(1) : '0;
        if (abort) begin
          state_d = IDLE;
        end else if (halt_in) begin
          state_d = DONE;
        end else if (STALL_EN && pc_match && (stall_cnt == STALL_LAST)) begin
          state_d   = DONE;
          stalled_d = 1'b1;
        end else if (cycles_consumed == CYC_LAST) begin
          state_d   = DONE;
          timeout_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the upcoming state so the flops reflect it after the edge
  always_comb begin
    cpu_rst_d = 1'b0;
    cpu_en_d  = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    case (state_d)
      HOLD: busy_d = 1'b1;
      RUN: begin
        cpu_rst_d = 1'b1;
        cpu_en_d  = 1'b1;
        busy_d    = 1'b1;
      end
      DONE: begin
        cpu_rst_d = 1'b1;
        done_d    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/cpu_run_controller.md
# cpu_run_controller

Run sequencer for the single-cycle CPU (`SC_CPU`). It holds the core in reset for a programmable number of cycles and releases it on a `start` request. It then counts executed cycles and stops the core on an explicit halt, on a self-loop (PC frozen), or on a cycle-budget timeout, reporting completion through a `busy`/`done` handshake. It replaces hand-coded reset and `MAX_CLOCKS` sequencing in benches and board top-levels.

## Interface
- `RESET_CYCLES`, default 2: cycles the CPU reset is held low before each run; must be ≥1.
- `MAX_CYCLES`, default 100000000: cycle budget per run; reaching it ends the run with `timeout`.
- `STALL_WINDOW`, default 8: consecutive cycles where PC equals the previous PC that end the run; 0 disables stall detection.
- `clk` in 1: the only clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-low reset.
- `start` in 1: run request, sampled in IDLE or DONE.
- `abort` in 1: cancels a run in HOLD or RUN.
- `halt_in` in 1: CPU halt indication, sampled in RUN.
- `pc` in 32: CPU program counter.
- `cpu_rst` out 1: active-low reset driven to `SC_CPU`.
- `cpu_en` out 1: CPU clock-enable.
- `cycles_consumed` out 32: RUN cycles executed in the current or last run.
- `busy` out 1: high in HOLD and RUN.
- `done` out 1: high in DONE.
- `timeout` out 1: valid with `done`; the run ended on the budget.
- `stalled` out 1: valid with `done`; the run ended on PC freeze.

## Operation
- All outputs are registered.
- Reset values: state IDLE, `cpu_rst`=0, `cpu_en`=0, `cycles_consumed`=0, `busy`=0, `done`=0, `timeout`=0, `stalled`=0. Internal stall counter and `pc_valid` are also 0.
- States and encoding: IDLE=0, HOLD=1, RUN=2, DONE=3.
- IDLE:
  - Outputs: `cpu_rst`=0, `cpu_en`=0.
  - `start`=1 → HOLD. The hold counter loads `RESET_CYCLES`-1. `cycles_consumed`, `timeout`, `stalled` and `pc_valid` clear.
- HOLD:
  - Outputs: `cpu_rst`=0, `cpu_en`=0, `busy`=1.
  - The counter decrements each cycle; at counter 0 → RUN.
  - `abort` → IDLE.
- RUN:
  - Outputs: `cpu_rst`=1, `cpu_en`=1, `busy`=1.
  - Each cycle `cycles_consumed` increments, saturating at 2^32-1. `pc_prev` loads `pc` and `pc_valid` sets.
  - If `pc_valid` and `pc`==`pc_prev`, the stall counter increments; otherwise it clears.
  - Exit priority, evaluated each RUN cycle:
    1. `abort` → IDLE.
    2. `halt_in` → DONE.
    3. Stall counter == `STALL_WINDOW`-1 with `pc`==`pc_prev` (STALL_WINDOW≠0) → DONE, `stalled`=1.
    4. `cycles_consumed`==`MAX_CYCLES`-1 → DONE, `timeout`=1.
  - The exiting cycle is itself counted.
- DONE:
  - Outputs: `cpu_rst`=1, `cpu_en`=0, `done`=1, `busy`=0.
  - The CPU is frozen, not reset, so its state stays inspectable.
  - `start` → HOLD, with the same clears as from IDLE.
  - `abort` is ignored.
- `cycles_consumed` is stable from DONE until the next `start` is accepted.
- Reset asserted in any state returns all registers to their reset values on the next edge. This takes priority over every other condition.

## Timing
- `start` sampled at edge E0:
  - `busy`=1 and `cpu_rst`=0 after E0.
  - `cpu_rst`=1 and `cpu_en`=1 after edge E0+`RESET_CYCLES`.
- RUN→DONE: `done`=1 after the same edge that samples the exit condition.
- Zero-latency exit flags: `timeout`/`stalled` become valid together with `done`.
- Stall example, `STALL_WINDOW`=8: PC constant from RUN cycle k gives the first match at cycle k+1. DONE follows the edge of cycle k+8.
- `start` and `abort` together in IDLE/DONE: `start` wins, since `abort` only acts in HOLD and RUN.
- `halt_in` and timeout in the same cycle: `timeout`=0.
- Reset-released `start` is honoured on the first edge after `rst`=1.

## Test plan
- Reset check: `rst`=0 for 3 cycles, then 1 with `start`=0 → all outputs 0 and state IDLE indefinitely.
- Explicit halt: `start` pulse, `RESET_CYCLES`=2, PC incrementing by 4, `halt_in` in the 10th RUN cycle → `cpu_rst` low 2 cycles, `done`=1, `cycles_consumed`=10, `timeout`=0, `stalled`=0.
- Stall halt: PC stops at 0x20 from RUN cycle 5, `STALL_WINDOW`=8 → `done`, `stalled`=1, `cycles_consumed`=13.
- Timeout: `MAX_CYCLES`=50, no halt, PC incrementing → `done`, `timeout`=1, `cycles_consumed`=50. `halt_in` at cycle 50 instead gives `timeout`=0.
- Abort and reset mid-operation:
  - `abort` in RUN cycle 6 → IDLE, `cpu_rst`=0, `done`=0.
  - `rst`=0 in RUN cycle 6 → reset values on the next edge.
- Rerun from DONE: `start` → counters clear, HOLD again, and the second run's `cycles_consumed` is independent of the first.
